// File: rtl/anode_scan_driver.sv
// Time-multiplexed anode scanner for a 4-digit display.
// Each digit owns a slot of REFRESH_DIV cycles, the first BLANK_CYCLES of which are dark
// to stop ghosting. Displayed values are double-buffered and only swapped at a frame
// boundary, so a frame never shows a mix of old and new digits.
module anode_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] YInput,
  input  logic [3:0] operation,
  output logic [3:0] anode,
  output logic [7:0] YDisp,
  output logic [3:0] opDisp,
  output logic       frame_tick
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic            en_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            slot_end, frame_end;
  logic            in_blank;

  logic            pending_q, pending_d;
  logic [7:0]      shadow_y_q, shadow_y_d;
  logic [3:0]      shadow_op_q, shadow_op_d;
  logic [7:0]      ydisp_q, ydisp_d;
  logic [3:0]      opdisp_q, opdisp_d;
  logic            frame_tick_q;

  // Dead-time window; a zero-length window needs no comparator at all.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (cnt_q < CntW'(BLANK_CYCLES));
  end

  // Scan position: counter runs only while the registered enable is high.
  always_comb begin
    slot_end  = en_q && (cnt_q == CntMax);
    frame_end = slot_end && (idx_q == 2'd3);
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    if (en_q) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    end
    if (slot_end) begin
      idx_d = idx_q + 2'd1;
    end
  end

  // Double buffer: loads park in the shadow until the frame ends, except a load on the
  // boundary cycle itself, which is already frame-aligned and goes straight through.
  always_comb begin
    pending_d   = pending_q;
    shadow_y_d  = shadow_y_q;
    shadow_op_d = shadow_op_q;
    ydisp_d     = ydisp_q;
    opdisp_d    = opdisp_q;
    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        ydisp_d  = YInput;
        opdisp_d = operation;
      end else if (pending_q) begin
        ydisp_d  = shadow_y_q;
        opdisp_d = shadow_op_q;
      end
    end else if (load) begin
      shadow_y_d  = YInput;
      shadow_op_d = operation;
      pending_d   = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      pending_q    <= 1'b0;
      shadow_y_q   <= 8'h00;
      shadow_op_q  <= 4'h0;
      ydisp_q      <= 8'h00;
      opdisp_q     <= 4'h0;
      frame_tick_q <= 1'b0;
    end else begin
      en_q         <= en;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      shadow_y_q   <= shadow_y_d;
      shadow_op_q  <= shadow_op_d;
      ydisp_q      <= ydisp_d;
      opdisp_q     <= opdisp_d;
      frame_tick_q <= frame_end;
    end
  end

  // Anode decode from registered state only, so inputs never reach the pins directly.
  always_comb begin
    anode = 4'b1111;
    if (en_q && !in_blank) begin
      unique case (idx_q)
        2'd0: anode = 4'b1110;
        2'd1: anode = 4'b1101;
        2'd2: anode = 4'b1011;
        2'd3: anode = 4'b0111;
        default: anode = 4'b1111;
      endcase
    end
  end

  assign YDisp      = ydisp_q;
  assign opDisp     = opdisp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/anode_scan_driver.md
ANODE_SCAN_DRIVER -- requirements
Module: anode_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (must be >= 2).
REQ-002 Parameter BLANK_CYCLES, default 1000, anti-ghosting dead time at the start of each slot (must be < REFRESH_DIV; 0 allowed).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  scan enable; 0 = display dark, scan frozen.
REQ-006 load  input  1  single-cycle strobe; capture YInput and operation.
REQ-007 YInput  input  8  ALU result to display.
REQ-008 operation  input  4  operation code to display.
REQ-009 anode  output  4  active-low one-hot digit select to display and decoder.
REQ-010 YDisp  output  8  frame-stable result for the decoder.
REQ-011 opDisp  output  4  frame-stable operation code for the decoder.
REQ-012 frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Slot counter cnt SHALL count 0..REFRESH_DIV-1 while en_q=1, wrapping to 0; held when en_q=0.
REQ-014 Digit index idx (2 bits) SHALL advance by 1, 3 wrapping to 0, on the cycle cnt wraps; held otherwise.
REQ-015 en_q SHALL be en registered once; all scan logic uses en_q.
REQ-016 anode SHALL be a decode of registered en_q, idx, cnt only (glitch-free, no input-to-output path).
REQ-017 anode = 4'b1111 when en_q=0 or cnt < BLANK_CYCLES.
REQ-018 Otherwise anode: idx0 -> 4'b1110, idx1 -> 4'b1101, idx2 -> 4'b1011, idx3 -> 4'b0111; never more than one bit low.
REQ-019 load=1 SHALL copy YInput/operation into shadow registers and set pending=1; load ignored-free: honoured regardless of en.
REQ-020 Frame boundary = cycle where idx=3, cnt=REFRESH_DIV-1, en_q=1.
REQ-021 At a frame boundary with pending=1, YDisp/opDisp SHALL take the shadow values and pending clears; YDisp/opDisp change at no other time (no mid-frame tearing).
REQ-022 load coincident with a frame boundary: the new YInput/operation go directly to YDisp/opDisp; pending ends 0.
REQ-023 Multiple loads within one frame: last load wins.
REQ-024 frame_tick SHALL be registered, high the cycle after each frame boundary, independent of pending.
REQ-025 en deasserted mid-slot: cnt/idx freeze; on re-enable scan resumes from the frozen cnt/idx.

Reset
REQ-026 rst_n=0 at a clock edge SHALL set cnt=0, idx=0, en_q=0, pending=0, shadow=0, YDisp=8'h00, opDisp=4'h0, frame_tick=0; anode therefore 4'b1111.
REQ-027 Reset asserted mid-frame discards any pending load and restarts from idx0, cnt=0.
REQ-028 Asynchronous change of rst_n between edges has no effect.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2 unless stated)
REQ-029 Reset then en=1 held: anode 1111 for first 3 cycles after release (en_q delay + blank), then 1110 for 6 cycles, 1111 ×2, 1101 ×6, ... 0111 ×6, repeat; frame_tick every 32 cycles.
REQ-030 load with YInput=8'hA5, operation=4'h3 mid-frame: YDisp/opDisp stay 00/0 until the boundary, then 8'hA5/4'h3; pending 0 afterwards.
REQ-031 load 8'h11 then 8'h22 same frame: after boundary YDisp=8'h22, never 8'h11.
REQ-032 load 8'h7E on the exact boundary cycle: YDisp=8'h7E next cycle; no extra update at the following boundary.
REQ-033 en=0 during idx2 slot for 10 cycles: anode 1111 throughout (from one cycle after en falls), cnt/idx frozen; after en=1 the idx2 slot completes its remaining count.
REQ-034 BLANK_CYCLES=0, rst_n pulsed low during idx3 with load pending: anode 1111 during reset, then 1110 immediately with en_q=1; YDisp=8'h00.
